// File: rtl/arbiter_pkt_mux.sv
// -----------------------------------------------------------------------------
// arbiter_pkt_mux
//
// Packet-level stream multiplexer placed directly behind an N-way round-robin
// arbiter. While idle it forwards the per-channel valids to the arbiter as
// requests. When a grant arrives it locks onto that channel for one whole
// packet, which ends with a last beat. The locked channel's beats are sent
// through a single registered valid/ready output stage. After the last beat
// the lock is released, so the arbiter's rotating priority picks the next
// packet.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   i_valid/i_data/i_last/o_ready   N input channels (channel k data at
//                                   i_data[k*DW +: DW])
//   o_req / i_grant request vector to arbiter / one-hot grant back
//   o_valid/o_data/o_last/i_ready   registered output stream
//   o_sel           one-hot owner of the current lock, zero when idle
//   o_wdog          (ARBITER_PKT_MUX_WDOG_EN only) one-cycle stall-abort pulse
//
// Optional feature: define ARBITER_PKT_MUX_WDOG_EN to add a stall watchdog.
// If a locked channel goes WDOG_CYC cycles without an accepted beat, the lock
// is dropped. The default build has no watchdog and no o_wdog port.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no lock; requests go to the arbiter, waiting for a grant
// LOCK  | o_sel channel owns the output until its last beat is accepted
// -----------------------------------------------------------------------------
module arbiter_pkt_mux #(
   parameter int N        = 4,
   parameter int DW       = 32,
   parameter int WDOG_CYC = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    i_valid,
   input  logic [N*DW-1:0] i_data,
   input  logic [N-1:0]    i_last,
   output logic [N-1:0]    o_ready,
   output logic [N-1:0]    o_req,
   input  logic [N-1:0]    i_grant,
   output logic            o_valid,
   output logic [DW-1:0]   o_data,
   output logic            o_last,
   output logic [N-1:0]    o_sel,
   input  logic            i_ready
`ifdef ARBITER_PKT_MUX_WDOG_EN
   ,
   output logic            o_wdog
`endif
);

   if (N < 2 || DW < 1 || WDOG_CYC < 1) begin : g_param_check
      $error("arbiter_pkt_mux: N must be >= 2, DW and WDOG_CYC >= 1");
   end

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t          state;
   logic [N-1:0]    gv;
   logic [N-1:0]    gv_low;
   logic [DW-1:0]   mux_data;
   logic            mux_valid;
   logic            mux_last;
   logic            out_free;
   logic            accept;

   // o_sel is the lock register itself. It is one-hot in LOCK and zero in
   // IDLE, so it can also serve as the input mux select.
   always_comb begin
      gv        = i_grant & i_valid;
      gv_low    = gv & (~gv + N'(1));
      mux_data  = '0;
      mux_valid = 1'b0;
      mux_last  = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (o_sel[k]) begin
            mux_data  = mux_data | i_data[k*DW +: DW];
            mux_valid = mux_valid | i_valid[k];
            mux_last  = mux_last | i_last[k];
         end
      end
   end

   assign out_free = !o_valid || i_ready;
   assign accept   = (state == LOCK) && out_free && mux_valid;

   // The arbiter grants combinationally from o_req. Requests are held low
   // outside IDLE so the arbiter's rotating mask stays put during a packet.
   // Both request and ready are also held low during reset, so no beat is
   // taken in a cycle whose result is about to be discarded.
   assign o_req   = (!rst && state == IDLE) ? i_valid : '0;
   assign o_ready = (!rst && state == LOCK && out_free) ? o_sel : '0;

`ifdef ARBITER_PKT_MUX_WDOG_EN
   localparam int            CW       = $clog2(WDOG_CYC + 1);
   localparam logic [CW-1:0] WDOG_LIM = CW'(WDOG_CYC);

   logic [CW-1:0] wdog_cnt;
   logic          wdog_fire;

   // The counter fires in the cycle in which it would reach WDOG_CYC.
   assign wdog_fire = (state == LOCK) && !accept && ((wdog_cnt + CW'(1)) == WDOG_LIM);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         o_sel   <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_last  <= 1'b0;
`ifdef ARBITER_PKT_MUX_WDOG_EN
         wdog_cnt <= '0;
         o_wdog   <= 1'b0;
`endif
      end else begin
         if (accept) begin
            o_valid <= 1'b1;
            o_data  <= mux_data;
            o_last  <= mux_last;
         end else if (i_ready) begin
            o_valid <= 1'b0;
         end

`ifdef ARBITER_PKT_MUX_WDOG_EN
         o_wdog <= 1'b0;
`endif

         case (state)
            IDLE: begin
               if (|gv) begin
                  state <= LOCK;
                  o_sel <= gv_low;
`ifdef ARBITER_PKT_MUX_WDOG_EN
                  wdog_cnt <= '0;
`endif
               end
            end
            LOCK: begin
               if (accept && mux_last) begin
                  state <= IDLE;
                  o_sel <= '0;
               end
`ifdef ARBITER_PKT_MUX_WDOG_EN
               else if (wdog_fire) begin
                  state  <= IDLE;
                  o_sel  <= '0;
                  o_wdog <= 1'b1;
               end

               if (accept || wdog_fire) begin
                  wdog_cnt <= '0;
               end else begin
                  wdog_cnt <= wdog_cnt + CW'(1);
               end
`endif
            end
            default: begin
               state <= IDLE;
               o_sel <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/arbiter_pkt_mux.md
Name: arbiter_pkt_mux

Overview:
- Packet-level stream multiplexer that sits directly downstream of the 4-way round-robin arbiter.
- Presents per-channel requests to the arbiter and accepts its one-hot grant. On a grant it locks onto that channel for a whole packet, terminated by last.
- Forwards the locked channel's beats through a registered valid/ready output stage.
- Releases the lock after the last beat so the arbiter's rotating priority decides the next packet.

Parameters:
- N, 4, number of input channels; must match the arbiter width.
- DW, 32, data width per channel.
- WDOG_CYC, 256, stall limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  N  per-channel beat valid.
- i_data  input  N*DW  per-channel data; channel k occupies bits [k*DW +: DW].
- i_last  input  N  per-channel end-of-packet flag.
- o_ready  output  N  per-channel ready.
- o_req  output  N  request vector to the arbiter.
- i_grant  input  N  one-hot grant from the arbiter (combinational from o_req).
- o_valid  output  1  output beat valid.
- o_data  output  DW  output data.
- o_last  output  1  output end-of-packet flag.
- o_sel  output  N  one-hot owner of the current lock; all zero when idle.
- i_ready  input  1  downstream ready.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. The reset condition is sampled at the clk edge.
  - state=IDLE, sel=0, o_valid=0, o_data=0, o_last=0, o_sel=0, o_ready=0, o_req=0.
  - Reset mid-packet drops the lock and any held output beat. The remainder of an interrupted packet is treated as a new packet; upstream is responsible for that case.
- FSM, 2 states, IDLE and LOCK.
  - IDLE:
    - o_req=i_valid; o_ready=0.
    - If (i_grant & i_valid)!=0, latch sel = lowest set bit of (i_grant & i_valid), then go to LOCK.
    - Otherwise stay in IDLE.
    - A multi-hot grant is resolved to its lowest bit; a grant to a non-valid channel is ignored.
  - LOCK:
    - o_req=0, so the arbiter issues no grant and its mask holds.
    - o_ready[sel] = !o_valid | i_ready; all other o_ready bits are 0.
    - An input beat is accepted when i_valid[sel] & o_ready[sel]. It is loaded into the output register: o_valid=1, o_data=i_data[sel], o_last=i_last[sel].
    - An accepted beat with i_last[sel]=1 sends the FSM to IDLE next cycle.
- Output register:
  - When o_valid & i_ready and no new load occurs, o_valid clears.
  - When o_valid & !i_ready, o_data and o_last are held stable.
  - Back-to-back beats run at full throughput: 1 beat per cycle with i_ready high.
- Latency:
  - Grant cycle (IDLE) to first o_ready[sel]: 1 cycle.
  - Input accept to o_valid: 1 cycle.
  - Packet-to-packet gap on the input side: exactly 1 IDLE cycle. The output may still hold the previous last beat during that IDLE cycle.
- Single-beat packet (i_last=1 on the first beat): LOCK lasts exactly 1 accepting cycle.
- o_sel = sel while in LOCK; 0 in IDLE.
- A channel dropping i_valid mid-packet keeps the lock; the block waits indefinitely unless the watchdog is compiled in.

Optional Feature:
- Macro: ARBITER_PKT_MUX_WDOG_EN.
- Defined:
  - Adds a counter that clears on every accepted input beat and on entry to LOCK.
  - The counter increments each LOCK cycle with no accept.
  - When it reaches WDOG_CYC, the FSM is forced to IDLE and output o_wdog (1 bit) pulses for 1 cycle. The held output register is unaffected.
  - The counter width is $clog2(WDOG_CYC+1).
- Undefined:
  - No counter and no o_wdog port.
  - The lock is released only by last.

Test Plan:
- All 4 channels send continuous 3-beat packets, i_ready=1 -> packets emerge ordered ch0,ch1,ch2,ch3,ch0. Each packet is 3 contiguous o_valid beats followed by a 1-cycle bubble; o_sel matches the source.
- Only ch1 and ch2 valid, 1-beat packets -> alternating ch1,ch2,ch1. o_req is high only in IDLE cycles; o_last=1 on every beat.
- ch0 locked with a 4-beat packet; i_ready toggles 1,0,0,1 -> no beat is lost or duplicated. o_data is stable while i_ready=0; o_ready[0]=0 while the output is full and stalled.
- ch2 mid-packet (beat 2 of 5) while ch0 and ch3 raise valid -> ch2 completes all 5 beats before o_req reasserts; the next grant is ch3.
- rst asserted during beat 2 of a ch1 packet -> next cycle o_valid=0, o_sel=0, state=IDLE; the next accepted beat follows a fresh grant.
- With ARBITER_PKT_MUX_WDOG_EN and WDOG_CYC=8: ch0 locked, i_valid[0] drops for 8 cycles -> o_wdog pulses once and the FSM returns to IDLE; the ch3 request is then granted.
